// File: rtl/upsample_pkg.sv
// Shared constants and types for the 2x horizontal line upsampler.
// Latency/backpressure: n/a (types only).
package upsample_pkg;

  localparam int DEF_PIX_W    = 8;
  localparam int DEF_PPW      = 2;
  localparam int DEF_LINE_PIX = 512;

  typedef enum logic {
    MODE_LINEAR  = 1'b0,
    MODE_NEAREST = 1'b1
  } mode_e;

  typedef enum logic {
    H0 = 1'b0,
    H1 = 1'b1
  } half_e;

endpackage

// File: rtl/upsample_interp.sv
// Midpoint between two neighbouring pixels, rounded half-up, or a replica of a in nearest mode.
// Latency: combinational; no flow control.
module upsample_interp
  import upsample_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  mode_e            mode,
  output logic [PIX_W-1:0] y
);

  logic [PIX_W:0] sum;

  // (a+b+1)>>1 == ((a+b)>>1) + lsb(a+b); the carry bit keeps the midpoint from wrapping.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (mode == MODE_NEAREST) ? a
                                 : sum[PIX_W:1] + {{(PIX_W-1){1'b0}}, sum[0]};
  end

endmodule

// File: rtl/upsample_line_engine.sv
// 2x horizontal upsampler: each input word yields two output words (linear or nearest).
// Latency: 1 cycle to first output; out_ready low stalls all state, in_ready drops when nxt fills.
module upsample_line_engine
  import upsample_pkg::*;
#(
  parameter int PIX_W    = DEF_PIX_W,
  parameter int PPW      = DEF_PPW,
  parameter int LINE_PIX = DEF_LINE_PIX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [PPW*PIX_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PPW*PIX_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int WORD_W = PPW * PIX_W;
  localparam int WPL    = LINE_PIX / PPW;
  localparam int HALF   = PPW / 2;
  localparam int CNT_W  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [CNT_W-1:0] LAST_TAG = CNT_W'(WPL - 1);

  // Each buffered word carries its end-of-line tag and the mode of the line it belongs to.
  typedef struct packed {
    logic [WORD_W-1:0] dat;
    logic              last;
    mode_e             mode;
  } slot_t;

  slot_t            cur, nxt, in_slot;
  logic             cur_vld, nxt_vld;
  logic [CNT_W-1:0] cnt;
  mode_e            line_mode;
  half_e            state, state_d;
  logic             in_acc, out_acc, h1_acc;

  assign in_ready = !nxt_vld;
  assign in_acc   = in_valid && in_ready;
  assign h1_acc   = out_acc && (state == H1);

  always_comb begin
    in_slot.dat  = in_data;
    in_slot.last = (cnt == LAST_TAG);
    in_slot.mode = (cnt == '0) ? mode_e'(mode) : line_mode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= H0;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (cur_vld) begin
      out_valid = (state == H0) || nxt_vld || cur.last;
      out_last  = (state == H1) && cur.last;
    end
    out_acc = out_valid && out_ready;
    if (out_acc) begin
      state_d = (state == H0) ? H1 : H0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      nxt       <= '0;
      cur_vld   <= 1'b0;
      nxt_vld   <= 1'b0;
      cnt       <= '0;
      line_mode <= MODE_LINEAR;
    end else begin
      if (in_acc) begin
        cnt <= (cnt == LAST_TAG) ? '0 : cnt + CNT_W'(1);
        if (cnt == '0) begin
          line_mode <= mode_e'(mode);
        end
      end
      if (h1_acc) begin
        // nxt can only be empty here if cur was a line end; an arriving word then refills cur.
        if (nxt_vld) begin
          cur     <= nxt;
          nxt_vld <= 1'b0;
        end else if (in_acc) begin
          cur <= in_slot;
        end else begin
          cur_vld <= 1'b0;
        end
      end else if (in_acc) begin
        if (!cur_vld) begin
          cur     <= in_slot;
          cur_vld <= 1'b1;
        end else begin
          nxt     <= in_slot;
          nxt_vld <= 1'b1;
        end
      end
    end
  end

  // pix[PPW] is the right-hand neighbour of the word: next word's first pixel or the edge replica.
  logic [PIX_W-1:0] pix [PPW+1];

  always_comb begin
    for (int j = 0; j < PPW; j++) begin
      pix[j] = cur.dat[j*PIX_W +: PIX_W];
    end
    pix[PPW] = cur.last ? cur.dat[(PPW-1)*PIX_W +: PIX_W] : nxt.dat[0 +: PIX_W];
  end

  for (genvar j = 0; j < HALF; j++) begin : g_interp
    logic [PIX_W-1:0] a, b, y;

    assign a = (state == H1) ? pix[HALF+j]   : pix[j];
    assign b = (state == H1) ? pix[HALF+j+1] : pix[j+1];

    upsample_interp #(.PIX_W(PIX_W)) u_interp (
      .a    (a),
      .b    (b),
      .mode (cur.mode),
      .y    (y)
    );

    assign out_data[(2*j)*PIX_W   +: PIX_W] = a;
    assign out_data[(2*j+1)*PIX_W +: PIX_W] = y;
  end

endmodule

// File: tb/tb_upsample_line_engine.sv
// Scoreboard bench for upsample_line_engine at PIX_W=8, PPW=2, LINE_PIX=4 (two words per line).
module tb_upsample_line_engine;

  localparam int PIX_W    = 8;
  localparam int PPW      = 2;
  localparam int LINE_PIX = 4;

  logic        clk = 1'b0;
  logic        rst, mode, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data, out_data;

  upsample_line_engine #(.PIX_W(PIX_W), .PPW(PPW), .LINE_PIX(LINE_PIX)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] dat;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pop_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] w(input int p0, input int p1);
    return {p1[7:0], p0[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    exp_q.push_back('{dat: d, last: last});
  endtask

  task automatic send_word(input logic [15:0] d, input logic m);
    int t;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (in_ready !== 1'b1 && t < 50);
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_drain_pending"}, exp_q.size(), 0);
  endtask

  // Monitor: one transfer per negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got 0x%0h last=%b, want no output", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.dat);
        check("out_last", out_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    // Linear interpolation with one-cycle first-output latency.
    @(posedge clk); #1;
    push(w(10, 15), 0); push(w(20, 25), 0); push(w(30, 35), 0); push(w(40, 40), 1);
    send_word(w(10, 20), 0);
    check("first_latency_valid", out_valid, 1);
    send_word(w(30, 40), 0);
    in_valid = 1'b0;
    wait_drain("linear");

    // Rounding and no-wrap at full scale.
    push(w(10, 11), 0); push(w(11, 133), 0); push(w(255, 255), 0); push(w(255, 255), 1);
    send_word(w(10, 11), 0);
    send_word(w(255, 255), 0);
    in_valid = 1'b0;
    wait_drain("round");

    // Nearest latched at tag 0; mid-line toggle to linear only applies to the next line.
    push(w(10, 10), 0); push(w(20, 20), 0); push(w(30, 30), 0); push(w(40, 40), 1);
    push(w(1, 2), 0);   push(w(3, 4), 0);   push(w(5, 6), 0);   push(w(7, 7), 1);
    send_word(w(10, 20), 1);
    send_word(w(30, 40), 0);
    send_word(w(1, 3), 0);
    send_word(w(5, 7), 0);
    in_valid = 1'b0;
    wait_drain("nearest");

    // Backpressure: outputs held for 5 cycles with both buffers full.
    out_ready = 1'b0;
    push(w(10, 15), 0); push(w(20, 25), 0); push(w(30, 35), 0); push(w(40, 40), 1);
    send_word(w(10, 20), 0);
    check("bp_in_ready_one_word", in_ready, 1);
    send_word(w(30, 40), 0);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_data", out_data, w(10, 15));
      check("bp_stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("backpressure");

    // Streaming: three lines back to back, one output per cycle.
    begin
      int base;
      base = pop_cyc.size();
      push(w(1, 2), 0);     push(w(3, 4), 0);     push(w(5, 6), 0);     push(w(7, 7), 1);
      push(w(0, 50), 0);    push(w(100, 150), 0); push(w(200, 125), 0); push(w(50, 50), 1);
      push(w(9, 9), 0);     push(w(9, 9), 0);     push(w(9, 9), 0);     push(w(8, 8), 1);
      send_word(w(1, 3), 0);
      send_word(w(5, 7), 0);
      send_word(w(0, 100), 0);
      send_word(w(200, 50), 0);
      send_word(w(9, 9), 0);
      send_word(w(9, 8), 0);
      in_valid = 1'b0;
      wait_drain("stream");
      if (pop_cyc.size() >= base + 12) begin
        check("stream_cycles_for_12", pop_cyc[base+11] - pop_cyc[base], 11);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL stream_count: got %0d outputs, want 12", pop_cyc.size() - base);
      end
    end

    // Reset mid-line discards the partial word; next word starts a fresh line.
    out_ready = 1'b0;
    send_word(w(10, 20), 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("prerst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push(w(30, 35), 0); push(w(40, 45), 0); push(w(50, 55), 0); push(w(60, 60), 1);
    send_word(w(30, 40), 0);
    send_word(w(50, 60), 0);
    in_valid = 1'b0;
    wait_drain("after_reset");

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/upsample_line_engine.md
UPSAMPLE_LINE_ENGINE -- requirements
Module: upsample_line_engine

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits.
REQ-002 Parameter PPW, default 2: pixels per bus word; SHALL be even and >= 2.
REQ-003 Parameter LINE_PIX, default 512: input pixels per line; SHALL be a multiple of PPW.
REQ-004 Derived WORD_W = PPW*PIX_W and WPL = LINE_PIX/PPW (words per line).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 mode  input  1  0 = linear interpolation, 1 = nearest (replicate).
REQ-008 in_data  input  WORD_W  input pixels; pixel j occupies bits [j*PIX_W +: PIX_W].
REQ-009 in_valid / in_ready  input / output  1 each  input handshake.
REQ-010 out_data  output  WORD_W  upsampled pixels, same packing as in_data.
REQ-011 out_valid / out_ready  output / input  1 each  output handshake.
REQ-012 out_last  output  1  high with the final output word of each line.

Function
REQ-013 Transfer SHALL occur on a rising edge where valid and ready are both high; unaccepted out_data/out_last SHALL hold stable while out_valid is high.
REQ-014 Buffering: two word registers, cur and nxt, each with a valid flag; in_ready SHALL equal !nxt_valid.
REQ-015 An accepted word SHALL load cur if cur is empty (or is being vacated that cycle), otherwise nxt.
REQ-016 A word counter (0..WPL-1, wrapping) SHALL tag each accepted word; cur_last is set when the tag equals WPL-1.
REQ-017 Each input word SHALL produce exactly two output words: half 0 from pixels 0..PPW/2-1, half 1 from pixels PPW/2..PPW-1.
REQ-018 Output pixel 2j SHALL equal p[j]; output pixel 2j+1 SHALL equal (p[j]+p[j+1]+1)>>1 in linear mode, p[j] in nearest mode.
REQ-019 The sum SHALL be computed at PIX_W+1 bits; the result SHALL never wrap.
REQ-020 p[PPW] SHALL be pixel 0 of nxt, or p[PPW-1] (edge replication) when cur_last.
REQ-021 Half 0 SHALL be valid whenever cur_valid; half 1 SHALL be valid only when cur_valid and (nxt_valid or cur_last).
REQ-022 FSM states: H0 (emitting half 0), H1 (emitting half 1); H0->H1 on half-0 acceptance; H1->H0 on half-1 acceptance.
REQ-023 On half-1 acceptance: cur takes nxt (and its tag) if nxt_valid, else cur becomes empty.
REQ-024 out_last SHALL be high exactly for half 1 of a cur_last word.
REQ-025 mode SHALL be latched when word tag 0 is accepted and held for the whole line; mid-line changes take effect at the next line.
REQ-026 Latency: first out_valid SHALL appear one cycle after the first input acceptance; with in_valid and out_ready held high, sustained throughput SHALL be one output word per cycle.
REQ-027 Simultaneous input acceptance and half-1 acceptance SHALL be lossless and in order.
REQ-028 out_ready low SHALL stall internal state without loss; in_ready falls once nxt is full.

Reset
REQ-029 On rst: cur/nxt valid flags 0, word counter 0, state H0, latched mode 0.
REQ-030 During and after reset: out_valid 0, out_last 0, out_data 0, in_ready 1.
REQ-031 Reset mid-line SHALL discard partial data; the next accepted word is tag 0 of a new line.

Structure
REQ-032 Package upsample_pkg SHALL hold the default PIX_W/PPW/LINE_PIX constants, the mode encoding, and the H0/H1 state type.
REQ-033 Sub-module upsample_interp (combinational: two pixels plus mode -> rounded interpolated pixel) SHALL be instantiated PPW/2 times per output half.

Verification (PIX_W=8, PPW=2, LINE_PIX=4)
REQ-034 Linear: words {10,20},{30,40} -> out {10,15},{20,25},{30,35},{40,40}; out_last on the fourth word only.
REQ-035 Rounding/overflow: word {10,11} then {255,255} -> first word {10,11}, {255,255} halves without wrap.
REQ-036 Nearest mode latched at tag 0: {10,20},{30,40} -> {10,10},{20,20},{30,30},{40,40}; a mode toggle mid-line is ignored until the next line.
REQ-037 Backpressure: out_ready low for 5 cycles mid-line -> out_data stable, in_ready low once nxt is full, sequence unchanged.
REQ-038 Streaming: in_valid and out_ready held high for 3 lines -> one output per cycle after fill; out_last every 4th output.
REQ-039 Reset after word 1 of a line -> out_valid 0 immediately; the next word is treated as line start.
